// File: rtl/wb_uart.sv
// wb_uart: Wishbone B4 classic slave UART with an 8N1 transmitter fed by a small FIFO.
// Define UART_RX_EN to build the optional receiver; without it RXDATA reads 0.
module wb_uart #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH-1:0]   S_DAT_I,
    input  logic [ADDR_WIDTH-1:0]   S_ADR_I,
    output logic [DATA_WIDTH-1:0]   S_DAT_O,
    input  logic                    S_WE_I,
    input  logic [DATA_WIDTH/8-1:0] S_SEL_I,
    input  logic                    S_STB_I,
    output logic                    S_ACK_O,
    input  logic                    S_CYC_I,
    output logic                    tx_o,
    input  logic                    rx_i
);

    localparam int             PW         = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]    FULL_COUNT = FIFO_DEPTH[PW:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_RXDATA = 2'd3;

    logic                  req, wr_req, rd_req;
    logic [1:0]            reg_sel;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [15:0]           baud_div, div_eff, div_m1;
    logic                  tx_overflow;

    logic [7:0]            mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic                  fifo_full, fifo_empty;
    logic                  push, push_ok, pop;
    logic [7:0]            fifo_head;

    logic [1:0]            state;
    logic [15:0]           baud_cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shift;
    logic                  bit_end, tx_busy, tx_level;

    logic                  rx_valid, rx_overrun;
    logic [7:0]            rx_byte;

    logic                  unused_ok;

    assign req     = S_STB_I & S_CYC_I & ~S_ACK_O;
    assign wr_req  = req & S_WE_I;
    assign rd_req  = req & ~S_WE_I;
    assign reg_sel = S_ADR_I[3:2];

    assign div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
    assign div_m1  = div_eff - 16'd1;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign fifo_head  = mem[rd_ptr];
    assign push       = wr_req && (reg_sel == REG_TXDATA) && S_SEL_I[0];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok    = push && (!fifo_full || pop);

    assign bit_end = (baud_cnt == 16'd0);
    assign tx_busy = (state != S_IDLE);
    assign pop     = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

    assign unused_ok = ^{S_DAT_I[DATA_WIDTH-1:16], S_ADR_I, S_SEL_I, rx_i};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATUS: rd_data[5:0]  = {rx_overrun, tx_overflow, rx_valid,
                                         fifo_empty, fifo_full, tx_busy};
            REG_BAUD:   rd_data[15:0] = baud_div;
            REG_RXDATA: rd_data[7:0]  = rx_byte;
            default:    rd_data       = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            S_ACK_O <= 1'b0;
            S_DAT_O <= '0;
        end else begin
            S_ACK_O <= req;
            S_DAT_O <= rd_req ? rd_data : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            baud_div    <= DEFAULT_DIV;
            tx_overflow <= 1'b0;
        end else begin
            if (wr_req && (reg_sel == REG_BAUD)) begin
                if (S_SEL_I[0]) baud_div[7:0]  <= S_DAT_I[7:0];
                if (S_SEL_I[1]) baud_div[15:8] <= S_DAT_I[15:8];
            end
            if (push && fifo_full && !pop)
                tx_overflow <= 1'b1;
            else if (rd_req && (reg_sel == REG_STATUS))
                tx_overflow <= 1'b0;
        end
    end

    // NOTE: FIFO storage has no reset; only the pointers and count need one to flush it.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= S_DAT_I[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        tx_level = 1'b1;
        case (state)
            S_START: tx_level = 1'b0;
            S_DATA:  tx_level = shift[0];
            default: tx_level = 1'b1;
        endcase
    end

    // tx_o is registered, so the line lags the FSM by one cycle but is glitch-free.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_o     <= 1'b1;
        end else begin
            tx_o <= tx_level;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift    <= fifo_head;
                        baud_cnt <= div_m1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= div_m1;
                        bit_idx  <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= div_m1;
                        shift    <= shift >> 1;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift    <= fifo_head;
                            baud_cnt <= div_m1;
                            state    <= S_START;
                        end else begin
                            state    <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_EN
    logic        rx_meta, rx_sync, rx_prev;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic        rx_read;

    assign rx_read = rd_req && (reg_sel == REG_RXDATA);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            // NOTE: these clears come first so a same-cycle set further down wins.
            if (rx_read) rx_valid <= 1'b0;
            if (rd_req && (reg_sel == REG_STATUS)) rx_overrun <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_cnt   <= div_eff >> 1;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (rx_sync) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_cnt   <= div_m1;
                            rx_idx   <= '0;
                            rx_state <= S_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                        rx_cnt   <= div_m1;
                        if (rx_idx == 3'd7) rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == 16'd0) begin
                        rx_state <= S_IDLE;
                        if (rx_sync) begin
                            if (rx_valid && !rx_read) begin
                                rx_overrun <= 1'b1;
                            end else begin
                                rx_byte  <= rx_shift;
                                rx_valid <= 1'b1;
                            end
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end
`else
    assign rx_valid   = 1'b0;
    assign rx_overrun = 1'b0;
    assign rx_byte    = 8'd0;
`endif

endmodule

// File: doc/wb_uart.md
# wb_uart

Wishbone B4 classic slave providing a memory-mapped UART on slave port 1 of the CPU Wishbone interconnect, alongside the memory on slave port 0. It accepts single-beat register reads and writes from the interconnect and buffers transmit bytes in a small FIFO. It serialises them as 8N1 frames on `tx_o` at a programmable baud divisor. An optional receiver can be compiled in.

## Interface
- `ADDR_WIDTH`, default 32: Wishbone address width.
- `DATA_WIDTH`, default 32: Wishbone data width; must be 32.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, ≥2.
- `DEFAULT_DIV`, default 16'd434: reset value of BAUD_DIV (50 MHz / 115200).
- `clk_i` in 1: single clock; all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `S_DAT_I` in DATA_WIDTH: write data.
- `S_ADR_I` in ADDR_WIDTH: address; only `[3:2]` decoded.
- `S_DAT_O` out DATA_WIDTH: read data, valid while `S_ACK_O`=1.
- `S_WE_I` in 1: 1 = write.
- `S_SEL_I` in DATA_WIDTH/8: byte lane enables.
- `S_STB_I` in 1: strobe.
- `S_ACK_O` out 1: acknowledge.
- `S_CYC_I` in 1: bus cycle.
- `tx_o` out 1: serial output, idle high.
- `rx_i` in 1: serial input; ignored unless `UART_RX_EN` is defined.

## Operation
- Register map (`S_ADR_I[3:2]`):
  - 0 TXDATA (W): `DAT_I[7:0]` is pushed to the FIFO if `SEL[0]`=1. Reads return 0.
  - 1 STATUS (R): bit0 tx_busy, bit1 fifo_full, bit2 fifo_empty, bit3 rx_valid, bit4 tx_overflow, bit5 rx_overrun; other bits 0. A read clears bits 4 and 5 in the ack cycle. Writes are ignored.
  - 2 BAUD_DIV (R/W): bits [15:0]; `SEL[0]` writes [7:0] and `SEL[1]` writes [15:8]. A value of 0 is treated as 1.
  - 3 RXDATA (R): `{24'd0, rx_byte}`. A read clears rx_valid. Writes are ignored.
- Bus handshake: when `S_STB_I & S_CYC_I & ~S_ACK_O`, the register access executes and `S_ACK_O` is driven high on the next cycle for exactly one cycle. `S_DAT_O` is registered with the ack and is 0 when the ack is low. There are no wait states and no error or retry.
- A TXDATA write while the FIFO is full drops the byte, sets tx_overflow (sticky) and still acks.
- TX FSM states are IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop a byte into the shift register and go to START.
  - START: `tx_o`=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each.
  - STOP: `tx_o`=1 for DIV cycles.
  - At the end of STOP, if the FIFO is not empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- tx_busy = (state ≠ IDLE).
- The baud counter loads DIV−1 at each bit start and counts down; the bit ends when the counter reaches 0. A BAUD_DIV write mid-frame takes effect at the next bit boundary.
- A simultaneous FIFO push and pop on a full FIFO is accepted: the pop frees the slot, no overflow is flagged, and the count is unchanged.

## Timing
- Reset values: `S_ACK_O`=0, `S_DAT_O`=0, `tx_o`=1. FIFO empty, FSM IDLE, BAUD_DIV=DEFAULT_DIV, all status flags 0.
- Reset asserted mid-frame: `tx_o` returns to 1 on the next edge and the FIFO is flushed.
- Access latency: ack one cycle after the strobe is sampled. Each back-to-back transaction takes 2 cycles.
- TXDATA write to FSM leaving IDLE: the push occurs at the ack edge and the pop on the following edge. The start bit appears on `tx_o` 2 cycles after the write strobe is sampled.
- Frame length: exactly 10×DIV cycles. A continuous stream of N bytes takes 10×N×DIV cycles.

## Configuration
- `UART_RX_EN` defined:
  - The receiver is built. `rx_i` passes through a 2-FF synchroniser.
  - A falling edge in RX idle starts a frame. The start bit is re-checked at DIV/2; a high sample aborts back to RX idle.
  - The 8 data bits are sampled mid-bit. A stop bit sampled low discards the byte.
  - A valid byte loads `rx_byte` and sets rx_valid. If rx_valid is already 1, the byte is dropped and rx_overrun is set.
- `UART_RX_EN` undefined: no RX logic. `rx_i` is unused, RXDATA reads 0, and STATUS bits 3 and 5 are always 0.

## Test plan
- Reset, then read STATUS → ack after 1 cycle with `S_DAT_O`=0x4; `tx_o`=1 throughout.
- BAUD_DIV=4, write TXDATA 0xA5 → `tx_o` shows 0,1,0,1,0,0,1,0,1,1, each bit lasting 4 cycles (40 cycles total); tx_busy drops afterwards.
- DIV=4, five writes 0x01..0x05 back-to-back with FIFO_DEPTH=4 → the fifth write is dropped only if it lands while the FIFO is full. The stream continues gap-free. A STATUS read shows bit4 matching the drop and clears it; a second read shows bit4=0.
- Write BAUD_DIV=0, then TXDATA 0xFF → each bit lasts 1 cycle and the frame is 10 cycles.
- Drive `rst_i`=0 for 1 cycle mid-DATA of a frame → `tx_o`=1 on the next edge, and STATUS=0x4 after reset.
- With `UART_RX_EN` and DIV=8: drive the 0x3C frame on `rx_i` → rx_valid=1 and RXDATA=0x3C. A second frame before any read sets rx_overrun, and RXDATA stays 0x3C.
